// File: rtl/mem_responder_if.sv
// mem_responder_if: core bus plus preload port shared between the
// 6502 core side (master) and the memory responder (slave).
interface mem_responder_if #(
   parameter int RAM_AW = 11
);
   logic [15:0]       address;
   logic              rw;
   logic [7:0]        wr_data;
   logic [7:0]        rd_data;
   logic              rdy;
   logic              bus_err;
   logic              ld_en;
   logic              ld_valid;
   logic [RAM_AW-1:0] ld_addr;
   logic [7:0]        ld_data;
   logic              ld_ready;

   modport master (
      output address, rw, wr_data, ld_en, ld_valid, ld_addr, ld_data,
      input  rd_data, rdy, bus_err, ld_ready
   );

   modport slave (
      input  address, rw, wr_data, ld_en, ld_valid, ld_addr, ld_data,
      output rd_data, rdy, bus_err, ld_ready
   );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: memory-side bus target for the 6502 core.
// Serves RAM at 0x0000..2^RAM_AW-1, a vector ROM at 0xFFFA..0xFFFF and a
// fill byte elsewhere, with one-cycle registered read data. A preload port
// fills RAM while in LOAD. Optional wait states are compiled in when the
// macro MEM_WAIT_STATES_EN is defined.
module mem_responder #(
   parameter int          RAM_AW       = 11,
   parameter logic [15:0] RESET_VECTOR = 16'h0200,
   parameter logic [7:0]  FILL_BYTE    = 8'hEA,
   parameter int          WAIT_CYCLES  = 2
) (
   input logic            clk,
   input logic            resetn,
   mem_responder_if.slave bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_LOAD} state_t;

   state_t            state_q, state_d;
   logic [7:0]        rd_data_q, rd_data_d;
   logic              rdy_q, rdy_d;
   logic              bus_err_q, bus_err_d;
   logic              ld_ready_q, ld_ready_d;
`ifdef MEM_WAIT_STATES_EN
   logic [3:0]        cnt_q, cnt_d;
   logic [15:0]       last_addr_q, last_addr_d;
`endif

   logic [7:0]        mem [2**RAM_AW];
   logic              is_ram;
   logic              is_vec;
   logic [RAM_AW-1:0] ram_idx;
   logic [7:0]        rd_val;
   logic              access;
   logic              mem_we;
   logic [RAM_AW-1:0] mem_waddr;
   logic [7:0]        mem_wdata;

   // Address decode and read-data selection for the current bus address.
   always_comb begin
      is_ram  = (bus.address >> RAM_AW) == 16'd0;
      is_vec  = bus.address >= 16'hFFFA;
      ram_idx = bus.address[RAM_AW-1:0];
      if (is_ram)
         rd_val = mem[ram_idx];
      else if (is_vec)
         rd_val = bus.address[0] ? RESET_VECTOR[15:8] : RESET_VECTOR[7:0];
      else
         rd_val = FILL_BYTE;
   end

   // Next-state logic; an access is performed only when 'access' is set.
   always_comb begin
      state_d   = state_q;
      rd_data_d = rd_data_q;
      bus_err_d = 1'b0;
      access    = 1'b0;
`ifdef MEM_WAIT_STATES_EN
      cnt_d       = cnt_q;
      last_addr_d = last_addr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.ld_en) begin
               state_d = ST_LOAD;
            end
`ifdef MEM_WAIT_STATES_EN
            else if (WAIT_CYCLES != 0 && bus.address != last_addr_q) begin
               state_d = ST_WAIT;
               cnt_d   = 4'(WAIT_CYCLES - 1);
            end
`endif
            else begin
               access = 1'b1;
            end
         end
`ifdef MEM_WAIT_STATES_EN
         ST_WAIT: begin
            if (bus.ld_en) begin
               state_d = ST_LOAD;
            end else if (cnt_q == 4'd0) begin
               access  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
`endif
         ST_LOAD: begin
            if (!bus.ld_en)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Reads refresh rd_data; writes outside RAM flag a bus error.
      if (access) begin
         if (bus.rw)
            rd_data_d = rd_val;
         else if (!is_ram)
            bus_err_d = 1'b1;
`ifdef MEM_WAIT_STATES_EN
         last_addr_d = bus.address;
`endif
      end

      rdy_d      = (state_d == ST_IDLE);
      ld_ready_d = (state_d == ST_LOAD);
   end

   // RAM write port: preload beats in LOAD, core writes otherwise.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = ram_idx;
      mem_wdata = bus.wr_data;
      if (state_q == ST_LOAD) begin
         mem_we    = bus.ld_valid;
         mem_waddr = bus.ld_addr;
         mem_wdata = bus.ld_data;
      end else if (access && !bus.rw && is_ram) begin
         mem_we = 1'b1;
      end
   end

   // RAM array; contents intentionally survive reset.
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_waddr] <= mem_wdata;
   end

   // Control and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         rd_data_q   <= 8'h00;
         rdy_q       <= 1'b1;
         bus_err_q   <= 1'b0;
         ld_ready_q  <= 1'b0;
`ifdef MEM_WAIT_STATES_EN
         cnt_q       <= 4'd0;
         last_addr_q <= 16'h0000;
`endif
      end else begin
         state_q     <= state_d;
         rd_data_q   <= rd_data_d;
         rdy_q       <= rdy_d;
         bus_err_q   <= bus_err_d;
         ld_ready_q  <= ld_ready_d;
`ifdef MEM_WAIT_STATES_EN
         cnt_q       <= cnt_d;
         last_addr_q <= last_addr_d;
`endif
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rdy      = rdy_q;
   assign bus.bus_err  = bus_err_q;
   assign bus.ld_ready = ld_ready_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table vectors, preload/reset sequences and random
// accesses checked against a transaction-level memory map model.
module tb_mem_responder;

   localparam int          RAM_AW   = 11;
   localparam int          RAM_SIZE = 1 << RAM_AW;
   localparam logic [15:0] RV       = 16'h0200;
   localparam logic [7:0]  FILL     = 8'hEA;
   localparam int          WC       = 2;
`ifdef MEM_WAIT_STATES_EN
   localparam bit WS_EN = 1'b1;
`else
   localparam bit WS_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic resetn = 1'b1;
   always #5 clk = ~clk;

   mem_responder_if #(.RAM_AW(RAM_AW)) bus ();

   mem_responder #(
      .RAM_AW(RAM_AW), .RESET_VECTOR(RV), .FILL_BYTE(FILL), .WAIT_CYCLES(WC)
   ) dut (
      .clk(clk), .resetn(resetn), .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [7:0]  m_mem [RAM_SIZE];
   logic [15:0] m_last_addr = 16'h0000;
   logic [7:0]  m_last_rd   = 8'h00;

   typedef struct {
      logic [15:0] addr;
      logic        rw;
      logic [7:0]  wd;
      logic [7:0]  exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t tbl[14];

   function automatic logic [7:0] model_read(input logic [15:0] a);
      if (int'(a) < RAM_SIZE) return m_mem[int'(a)];
      if (a >= 16'hFFFA) return a[0] ? 8'(RV >> 8) : 8'(RV & 16'h00FF);
      return FILL;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string name);
      chk({name, "_rd_data"}, 32'(bus.rd_data), 32'h00);
      chk({name, "_rdy"}, 32'(bus.rdy), 32'h1);
      chk({name, "_bus_err"}, 32'(bus.bus_err), 32'h0);
      chk({name, "_ld_ready"}, 32'(bus.ld_ready), 32'h0);
   endtask

   // Assert reset away from a clock edge, check outputs, release later.
   task automatic do_reset(input string name);
      resetn = 1'b0;
      #1;
      chk_reset_vals(name);
      bus.ld_en    = 1'b0;
      bus.ld_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3;
      resetn      = 1'b1;
      m_last_addr = 16'h0000;
      m_last_rd   = 8'h00;
   endtask

   // One core access: drive, wait for rdy, check against the model.
   task automatic do_access(input logic [15:0] a, input logic r, input logic [7:0] wd,
                            input string name);
      int  stalls = 0;
      bit  done = 0;
      int  exp_stalls;
      logic exp_err;
      exp_stalls = (WS_EN && WC != 0 && a != m_last_addr) ? WC : 0;
      bus.address = a;
      bus.rw      = r;
      bus.wr_data = wd;
      for (int i = 0; i < 40 && !done; i++) begin
         @(posedge clk);
         #1;
         if (bus.rdy) done = 1;
         else stalls++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout rdy never returned high", name);
      end
      m_last_addr = a;
      exp_err = !r && (int'(a) >= RAM_SIZE);
      if (r) m_last_rd = model_read(a);
      else if (int'(a) < RAM_SIZE) m_mem[int'(a)] = wd;
      chk({name, "_stalls"}, 32'(stalls), 32'(exp_stalls));
      chk({name, "_bus_err"}, 32'(bus.bus_err), 32'(exp_err));
      if (r) chk({name, "_rd_data"}, 32'(bus.rd_data), 32'(m_last_rd));
      $display("access %s addr=%04h rw=%0d wd=%02h rd=%02h err=%0d stalls=%0d",
               name, a, r, wd, bus.rd_data, bus.bus_err, stalls);
   endtask

   initial begin
      logic [15:0] a;
      logic        r;
      logic [7:0]  d;
      logic [7:0]  pre_data [3];

      tbl[0]  = '{16'hFFFC, 1'b1, 8'h00, 8'h00, 1'b0};
      tbl[1]  = '{16'hFFFD, 1'b1, 8'h00, 8'h02, 1'b0};
      tbl[2]  = '{16'h0123, 1'b0, 8'h5A, 8'h00, 1'b0};
      tbl[3]  = '{16'h0123, 1'b1, 8'h00, 8'h5A, 1'b0};
      tbl[4]  = '{16'h0800, 1'b1, 8'h00, 8'hEA, 1'b0};
      tbl[5]  = '{16'hFFFC, 1'b0, 8'h11, 8'h00, 1'b1};
      tbl[6]  = '{16'hFFFC, 1'b1, 8'h00, 8'h00, 1'b0};
      tbl[7]  = '{16'hFFFA, 1'b1, 8'h00, 8'h00, 1'b0};
      tbl[8]  = '{16'hFFFF, 1'b1, 8'h00, 8'h02, 1'b0};
      tbl[9]  = '{16'hFFF9, 1'b1, 8'h00, 8'hEA, 1'b0};
      tbl[10] = '{16'h07FF, 1'b0, 8'h77, 8'h00, 1'b0};
      tbl[11] = '{16'h07FF, 1'b1, 8'h00, 8'h77, 1'b0};
      tbl[12] = '{16'h0800, 1'b0, 8'h33, 8'h00, 1'b1};
      tbl[13] = '{16'h0800, 1'b1, 8'h00, 8'hEA, 1'b0};
      pre_data[0] = 8'hA9;
      pre_data[1] = 8'h42;
      pre_data[2] = 8'hEA;

      bus.address  = 16'h0000;
      bus.rw       = 1'b1;
      bus.wr_data  = 8'h00;
      bus.ld_en    = 1'b0;
      bus.ld_valid = 1'b0;
      bus.ld_addr  = '0;
      bus.ld_data  = 8'h00;

      #2;
      do_reset("reset");

      // Table vectors
      for (int i = 0; i < 14; i++) begin
         do_access(tbl[i].addr, tbl[i].rw, tbl[i].wd, $sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d_err_const", i), 32'(bus.bus_err), 32'(tbl[i].exp_err));
         if (tbl[i].rw)
            chk($sformatf("tbl%0d_rd_const", i), 32'(bus.rd_data), 32'(tbl[i].exp_rd));
      end

      // Preload three beats with valid gaps
      bus.ld_en = 1'b1;
      @(posedge clk); #1;
      chk("load_enter_ld_ready", 32'(bus.ld_ready), 32'h1);
      chk("load_enter_rdy", 32'(bus.rdy), 32'h0);
      for (int i = 0; i < 3; i++) begin
         bus.ld_valid = 1'b1;
         bus.ld_addr  = RAM_AW'(i);
         bus.ld_data  = pre_data[i];
         m_mem[i]     = pre_data[i];
         @(posedge clk); #1;
         chk($sformatf("load_beat%0d_rdy", i), 32'(bus.rdy), 32'h0);
         chk($sformatf("load_beat%0d_rd_hold", i), 32'(bus.rd_data), 32'(m_last_rd));
         bus.ld_valid = 1'b0;
         @(posedge clk); #1;
         chk($sformatf("load_gap%0d_rdy", i), 32'(bus.rdy), 32'h0);
      end
      bus.ld_en = 1'b0;
      @(posedge clk); #1;
      chk("load_exit_ld_ready", 32'(bus.ld_ready), 32'h0);
      chk("load_exit_rdy", 32'(bus.rdy), 32'h1);
      do_access(16'h0000, 1'b1, 8'h00, "pre0");
      do_access(16'h0001, 1'b1, 8'h00, "pre1");
      do_access(16'h0002, 1'b1, 8'h00, "pre2");
      chk("pre2_const", 32'(bus.rd_data), 32'hEA);

      // Fill all RAM through the preload port
      bus.ld_en = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < RAM_SIZE; i++) begin
         bus.ld_valid = 1'b1;
         bus.ld_addr  = RAM_AW'(i);
         bus.ld_data  = 8'($urandom);
         m_mem[i]     = bus.ld_data;
         @(posedge clk); #1;
      end
      bus.ld_valid = 1'b0;
      bus.ld_en    = 1'b0;
      @(posedge clk); #1;

      // Address change then repeat: stall only on the change
      do_access(16'h0010, 1'b1, 8'h00, "ws_a");
      do_access(16'h0011, 1'b1, 8'h00, "ws_b");
      do_access(16'h0011, 1'b1, 8'h00, "ws_repeat");

      // Random accesses
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: a = 16'($urandom_range(0, RAM_SIZE - 1));
            6:                a = m_last_addr;
            7:                a = 16'($urandom_range(16'hFFFA, 16'hFFFF));
            8:                a = 16'($urandom_range(RAM_SIZE, 16'hFFF9));
            default:          a = 16'($urandom);
         endcase
         r = ($urandom_range(0, 3) != 0);
         d = 8'($urandom);
         do_access(a, r, d, $sformatf("rnd%0d", n));
      end

`ifdef MEM_WAIT_STATES_EN
      // Reset while a wait is pending
      bus.address = 16'h0300;
      bus.rw      = 1'b1;
      @(posedge clk); #1;
      chk("mid_wait_rdy_low", 32'(bus.rdy), 32'h0);
      do_reset("rst_wait");
      do_access(16'hFFFD, 1'b1, 8'h00, "after_rst_wait");
`endif

      // Reset while in LOAD
      bus.ld_en = 1'b1;
      @(posedge clk); #1;
      chk("mid_load_ld_ready", 32'(bus.ld_ready), 32'h1);
      do_reset("rst_load");
      do_access(16'hFFFD, 1'b1, 8'h00, "after_rst_load");
      chk("after_rst_load_ld_ready", 32'(bus.ld_ready), 32'h0);
      do_access(16'h0001, 1'b1, 8'h00, "after_rst_ram");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side bus target for the 6502 core. Samples the core's `address`/`rw`/`wr_data` every cycle and returns `rd_data` with one-cycle registered latency, serving internal RAM, a fixed vector ROM at 0xFFFA–0xFFFF and a fill byte for unmapped space. Also provides a preload port for filling RAM while the core is held in reset, and an optional `rdy` wait-state generator.

## Interface
- `RAM_AW`, 11, RAM address width; RAM occupies 0x0000 to 2^RAM_AW−1.
- `RESET_VECTOR`, 16'h0200, value returned for the NMI, RESET and IRQ vector pairs.
- `FILL_BYTE`, 8'hEA, read data for unmapped addresses.
- `WAIT_CYCLES`, 2, stall cycles per new access; used only with `MEM_WAIT_STATES_EN`; range 0–15.
- `clk` in 1, single clock.
- `resetn` in 1, asynchronous, active-low reset.
- `address` in 16, core bus address.
- `rw` in 1, 1 = read, 0 = write.
- `wr_data` in 8, write data.
- `rd_data` out 8, registered read data.
- `rdy` out 1, 1 = `rd_data` valid and write accepted this cycle.
- `bus_err` out 1, one-cycle pulse on a write to a non-RAM address.
- `ld_en` in 1, preload mode request.
- `ld_valid` in 1, preload beat valid.
- `ld_addr` in RAM_AW, preload address.
- `ld_data` in 8, preload data.
- `ld_ready` out 1, preload beat accepted when high together with `ld_valid`.

## Operation
- Address decode:
  - RAM when `address < 2^RAM_AW`.
  - Vector ROM at 0xFFFA–0xFFFF: even address returns `RESET_VECTOR[7:0]`, odd returns `RESET_VECTOR[15:8]`.
  - Everything else returns `FILL_BYTE`.
- Write (`rw`=0):
  - To RAM: stores `wr_data`.
  - Elsewhere: ignored, and `bus_err` pulses 1 on the next cycle.
- State machine: IDLE, WAIT, LOAD. Reset state is IDLE.
  - IDLE: performs the access every cycle.
    - `ld_en`=1 → LOAD. This has priority over any access in the same cycle.
    - Otherwise, with the macro on, WAIT_CYCLES>0 and `address` different from `last_addr` → WAIT, with `cnt`=WAIT_CYCLES−1, `rdy`=0 and no access performed.
  - WAIT: `cnt` decrements each cycle.
    - At `cnt`=0, the access is performed using the current `address`/`rw`, then → IDLE.
    - `ld_en`=1 → LOAD, and the pending access is dropped.
  - LOAD: `rdy`=0 and `ld_ready`=1.
    - Each cycle with `ld_valid`=1, writes `ld_data` to `ld_addr`.
    - `ld_en`=0 → IDLE.
    - `rd_data` holds its previous value.
- `last_addr` updates to `address` whenever an access is performed.
- RAM contents are not cleared by reset.

## Timing
- Reset values: `rd_data`=8'h00, `rdy`=1, `bus_err`=0, `ld_ready`=0, `last_addr`=16'h0000, state IDLE.
- Read latency with no wait: `address` sampled at edge N, `rd_data` valid after edge N+1 and held until the next access completes.
- Write: committed at the sampling edge. A read of the same address on the next cycle returns the new data.
- Wait path: `rdy` drops the cycle after the address change and stays low for exactly WAIT_CYCLES cycles. `rd_data` updates on the edge that raises `rdy`.
- Back-to-back identical addresses incur no wait.
- `ld_ready` rises one cycle after `ld_en` is sampled high and falls one cycle after `ld_en` is sampled low.
- Asserting `resetn` mid-WAIT or mid-LOAD forces all reset values immediately; the pending access is lost.

## Configuration
- `MEM_WAIT_STATES_EN`:
  - Defined: wait-state path and WAIT state compiled in.
  - Undefined: no WAIT state and no counter; `rdy`=1 except in LOAD, every access completes with 1-cycle latency, and `WAIT_CYCLES` is ignored.

## Test plan
- Vector read: after reset, `address`=0xFFFC then 0xFFFD, `rw`=1, macro off → `rd_data`=8'h00 then 8'h02 on consecutive cycles.
- RAM round trip: write 8'h5A to 0x0123, then read 0x0123 → `rd_data`=8'h5A one cycle later, `bus_err` stays 0.
- Decode edges:
  - Read 0x0800 → 8'hEA.
  - Write 8'h11 to 0xFFFC → `bus_err` one-cycle pulse.
  - Subsequent read of 0xFFFC still returns 8'h00.
- Preload: `ld_en`=1, then 3 beats 0x000–0x002 = 8'hA9, 8'h42, 8'hEA with `ld_valid` gaps; drop `ld_en`, read back → exact bytes, `rdy`=0 throughout LOAD.
- Wait states, macro on, WAIT_CYCLES=2:
  - Change address 0x0010→0x0011 → `rdy` low exactly 2 cycles, then data valid.
  - Repeated 0x0011 → no stall.
- Reset mid-operation: deassert `resetn` during WAIT and during LOAD → all outputs at reset values immediately, state IDLE after release.
